mem_req_unit: RTL and testbench
===============================

Name: mem_req_unit

Overview:
- MEM-stage initiator for the data-memory (D-cache) port; write/request counterpart of the WB load-extraction logic.
- Converts a load/store from the pipeline into a word-aligned cache request with byte enables and lane-replicated store data.
- Holds the request until the cache responds and stalls the pipeline meanwhile.
- Captures read data into mdrreg_out and forwards the byte enable that WB uses for lb/lbu/lh/lhu extraction.

Parameters:
- LAT_W, 16, width of the saturating request-latency counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  a memory op is present in MEM this cycle
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I funct3 (lb 000, lh 001, lw 010, lbu 100, lhu 101; sb 000, sh 001, sw 010)
- req_addr  in  32  effective byte address (alu_out)
- req_wdata  in  32  rs2 value for stores
- data_mem_address  out  32  {req_addr[31:2],2'b00}, registered
- data_mem_read  out  1  cache read strobe, registered
- data_mem_write  out  1  cache write strobe, registered
- data_mem_wdata  out  32  lane-aligned store data, registered
- data_mem_byte_enable  out  4  byte mask, registered; held until next accepted request
- data_mem_resp  in  1  cache completion, one-cycle pulse
- data_mem_rdata  in  32  cache read data, valid with resp
- mdrreg_out  out  32  captured read word
- stall  out  1  freeze pipeline upstream of and including MEM
- done  out  1  one-cycle pulse: access finished
- fault  out  1  one-cycle pulse: misaligned or illegal funct3, no request issued
- last_latency  out  LAT_W  cycles from accept to resp of the most recent access

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE; all outputs 0, including mdrreg_out, data_mem_byte_enable and last_latency; the latency counter clears.
- Reset applied mid-access drops read/write at that edge; any later resp received in IDLE is ignored.
- Byte-enable and data rules, with a = req_addr[1:0]:
  - byte ops (funct3[1:0]=00): mbe = 4'b0001<<a; wdata = {4{req_wdata[7:0]}}
  - half ops (funct3[1:0]=01): mbe = a[1]?1100:0011; wdata = {2{req_wdata[15:0]}}
  - word ops (funct3[1:0]=10): mbe = 1111; wdata = req_wdata
  - loads compute mbe the same way; wdata is don't-care and is driven 0.
- Fault conditions: half op with a[0]=1; word op with a!=00; store with funct3[2]=1; any funct3[1:0]=11.
- Fault handling (IDLE only, req_valid high): fault pulses in that same cycle (combinational); no request is issued, stall=0, state stays IDLE.
- States:
  - IDLE: on req_valid && !fault, register address, mbe and wdata, and set read=!req_store / write=req_store at the edge; clear the latency counter; go to BUSY.
  - IDLE stall is combinational: stall = req_valid && !fault.
  - BUSY: read/write and all request fields are held stable. stall=1. The counter increments each cycle, saturating at all-ones.
  - BUSY exit: when resp=1, at the edge deassert read/write, latch mdrreg_out=rdata (loads only; stores leave it unchanged), latch last_latency=counter+1 (saturating), and go to DONE.
  - DONE: done=1, stall=0, so the pipeline advances at this edge. Next state is IDLE unconditionally; req_valid is not sampled in DONE.
- Minimum occupancy is 3 cycles: accept, BUSY with resp, DONE. Back-to-back memory ops are therefore separated by at least one IDLE cycle.
- resp is sampled only in BUSY. Any resp in IDLE or DONE is ignored.
- Exactly one of data_mem_read / data_mem_write is ever high, and only in BUSY.
- data_mem_byte_enable stays valid through DONE and beyond, so WB reads the mask belonging to the completed load.

Test Plan:
- sb: addr=0x1003, wdata=0xAABBCCDD, resp 2 cycles after accept -> address=0x1000, write=1, mbe=1000, wdata=0xDDDDDDDD; stall high 3 cycles; done pulse; last_latency=2.
- lh: addr=0x2002, resp with rdata=0x8001_7FFF in the first BUSY cycle -> read=1, mbe=1100; mdrreg_out=0x80017FFF; done on the 3rd cycle; last_latency=1.
- Misaligned lw: addr=0x3001 -> fault=1 same cycle, stall=0, read/write stay 0, state IDLE. Then lhu at addr=0x3001 -> also faults.
- Spurious resp in IDLE and DONE, plus a back-to-back sw after a load -> mdrreg_out unchanged by the spurious resps; the sw is accepted only from IDLE, with mbe=1111 and wdata=rs2.
- rst=0 asserted during BUSY, then resp arrives after release -> read=0 after that edge, state IDLE, no done pulse, mdrreg_out=0.
- resp withheld 70000 cycles with LAT_W=16 -> last_latency=0xFFFF (saturated); stall held throughout.

Source files
------------

// File: rtl/mem_req_unit.sv
// mem_req_unit: MEM-stage data-memory request initiator.
// Turns a pipeline load/store into a word-aligned cache request with byte
// enables and lane-replicated store data, holds it until the cache responds,
// stalls the pipeline meanwhile and captures the read word for WB.
module mem_req_unit #(
  parameter int unsigned LAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic [31:0]      data_mem_address,
  output logic             data_mem_read,
  output logic             data_mem_write,
  output logic [31:0]      data_mem_wdata,
  output logic [3:0]       data_mem_byte_enable,
  input  logic             data_mem_resp,
  input  logic [31:0]      data_mem_rdata,
  output logic [31:0]      mdrreg_out,
  output logic             stall,
  output logic             done,
  output logic             fault,
  output logic [LAT_W-1:0] last_latency
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [LAT_W-1:0] LAT_MAX = {LAT_W{1'b1}};
  localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};

  // Access size encoding taken from funct3[1:0].
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // An op is illegal when misaligned for its size, when a store asks for the
  // unsigned (load-only) variants, or when the size field is the unused 11.
  function automatic logic op_illegal(input logic       store,
                                      input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = a[0];
      SZ_WORD: bad = (a != 2'b00);
      default: bad = 1'b1;
    endcase
    if (store && f3[2]) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

  // Byte mask for the addressed lanes; loads use the same mask so WB can
  // pick the right bytes out of the returned word.
  function automatic logic [3:0] lane_mask(input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (f3[1:0])
      SZ_BYTE: m = 4'b0001 << a;
      SZ_HALF: m = a[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

  // Store data replicated across every lane so the mask alone selects the
  // bytes written; loads drive zero.
  function automatic logic [31:0] lane_data(input logic        store,
                                            input logic [2:0]  f3,
                                            input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0000_0000;
    if (store) begin
      case (f3[1:0])
        SZ_BYTE: w = {4{d[7:0]}};
        SZ_HALF: w = {2{d[15:0]}};
        SZ_WORD: w = d;
        default: w = 32'h0000_0000;
      endcase
    end else begin
      w = 32'h0000_0000;
    end
    return w;
  endfunction

  // Saturating increment for the latency counter.
  function automatic logic [LAT_W-1:0] sat_inc(input logic [LAT_W-1:0] v);
    logic [LAT_W-1:0] r;
    if (v == LAT_MAX) begin
      r = LAT_MAX;
    end else begin
      r = v + LAT_ONE;
    end
    return r;
  endfunction

  state_e             state_q, state_d;
  logic [31:0]        addr_q, addr_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         mbe_q, mbe_d;
  logic [31:0]        mdr_q, mdr_d;
  logic [LAT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic [LAT_W-1:0]   last_lat_q, last_lat_d;

  logic               illegal_s;
  logic               fault_s;
  logic               stall_s;
  logic               done_s;

  // Legality of the op currently presented by the pipeline.
  always_comb begin
    illegal_s = op_illegal(req_store, req_funct3, req_addr[1:0]);
  end

  // Next-state, request capture, latency tracking and pipeline handshake.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    mbe_d      = mbe_q;
    mdr_d      = mdr_q;
    lat_cnt_d  = lat_cnt_q;
    last_lat_d = last_lat_q;
    fault_s    = 1'b0;
    stall_s    = 1'b0;
    done_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (illegal_s) begin
            fault_s = 1'b1;
          end else begin
            stall_s   = 1'b1;
            addr_d    = {req_addr[31:2], 2'b00};
            mbe_d     = lane_mask(req_funct3, req_addr[1:0]);
            wdata_d   = lane_data(req_store, req_funct3, req_wdata);
            rd_d      = ~req_store;
            wr_d      = req_store;
            lat_cnt_d = LAT_ZERO;
            state_d   = ST_BUSY;
          end
        end else begin
          stall_s = 1'b0;
        end
      end

      ST_BUSY: begin
        stall_s = 1'b1;
        if (data_mem_resp) begin
          rd_d       = 1'b0;
          wr_d       = 1'b0;
          last_lat_d = sat_inc(lat_cnt_q);
          if (rd_q) begin
            mdr_d = data_mem_rdata;
          end else begin
            mdr_d = mdr_q;
          end
          state_d = ST_DONE;
        end else begin
          lat_cnt_d = sat_inc(lat_cnt_q);
        end
      end

      ST_DONE: begin
        done_s  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'h0000_0000;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      wdata_q    <= 32'h0000_0000;
      mbe_q      <= 4'b0000;
      mdr_q      <= 32'h0000_0000;
      lat_cnt_q  <= LAT_ZERO;
      last_lat_q <= LAT_ZERO;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      wdata_q    <= wdata_d;
      mbe_q      <= mbe_d;
      mdr_q      <= mdr_d;
      lat_cnt_q  <= lat_cnt_d;
      last_lat_q <= last_lat_d;
    end
  end

  // Output mapping.
  always_comb begin
    data_mem_address     = addr_q;
    data_mem_read        = rd_q;
    data_mem_write       = wr_q;
    data_mem_wdata       = wdata_q;
    data_mem_byte_enable = mbe_q;
    mdrreg_out           = mdr_q;
    last_latency         = last_lat_q;
    stall                = stall_s;
    done                 = done_s;
    fault                = fault_s;
  end

endmodule

// File: tb/tb_mem_req_unit.sv
// tb_mem_req_unit: directed plus randomized checks of mem_req_unit against a
// behavioural model of the memory-request rules.
module tb_mem_req_unit;

  localparam int LAT_W = 16;
  localparam int LAT_CAP = (1 << LAT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_store;
  logic [2:0]       req_funct3;
  logic [31:0]      req_addr;
  logic [31:0]      req_wdata;
  logic [31:0]      data_mem_address;
  logic             data_mem_read;
  logic             data_mem_write;
  logic [31:0]      data_mem_wdata;
  logic [3:0]       data_mem_byte_enable;
  logic             data_mem_resp;
  logic [31:0]      data_mem_rdata;
  logic [31:0]      mdrreg_out;
  logic             stall;
  logic             done;
  logic             fault;
  logic [LAT_W-1:0] last_latency;

  always #5 clk = ~clk;

  mem_req_unit #(.LAT_W(LAT_W)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .req_valid            (req_valid),
    .req_store            (req_store),
    .req_funct3           (req_funct3),
    .req_addr             (req_addr),
    .req_wdata            (req_wdata),
    .data_mem_address     (data_mem_address),
    .data_mem_read        (data_mem_read),
    .data_mem_write       (data_mem_write),
    .data_mem_wdata       (data_mem_wdata),
    .data_mem_byte_enable (data_mem_byte_enable),
    .data_mem_resp        (data_mem_resp),
    .data_mem_rdata       (data_mem_rdata),
    .mdrreg_out           (mdrreg_out),
    .stall                (stall),
    .done                 (done),
    .fault                (fault),
    .last_latency         (last_latency)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: what the unit should be presenting.
  logic [31:0]      exp_addr  = 32'h0;
  logic [31:0]      exp_wdata = 32'h0;
  logic [3:0]       exp_mbe   = 4'h0;
  logic [31:0]      exp_mdr   = 32'h0;
  logic [LAT_W-1:0] exp_last  = '0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_illegal(input bit st, input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = int'(f3[1:0]);
    if (sz == 3) return 1'b1;
    if (st && f3[2]) return 1'b1;
    if ((a % (1 << sz)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_mbe(input logic [2:0] f3, input logic [31:0] a);
    int nbytes;
    nbytes = 1 << int'(f3[1:0]);
    return 4'(((1 << nbytes) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(input bit st, input logic [2:0] f3, input logic [31:0] d);
    if (!st) return 32'h0;
    case (f3[1:0])
      2'b00:   return (d % 256) * 32'h0101_0101;
      2'b01:   return (d % 65536) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // Registered outputs that must persist while the unit is idle.
  task automatic check_held(input string tag);
    check_val({tag, "_read"}, data_mem_read, 1'b0);
    check_val({tag, "_write"}, data_mem_write, 1'b0);
    check_val({tag, "_mbe"}, data_mem_byte_enable, exp_mbe);
    check_val({tag, "_mdr"}, mdrreg_out, exp_mdr);
    check_val({tag, "_done"}, done, 1'b0);
  endtask

  task automatic spur_idle();
    req_valid      = 1'b0;
    data_mem_resp  = 1'b1;
    data_mem_rdata = $urandom;
    tick();
    data_mem_resp = 1'b0;
    check_held("spur_idle");
  endtask

  // One access from IDLE. delay = BUSY cycle in which resp arrives (1 = first).
  // hold_next: in DONE, raise a spurious resp and present a new op that must
  // not be accepted until IDLE.
  task automatic do_access(input bit st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int delay, input logic [31:0] rd,
                           input bit hold_next);
    int stall_low;
    req_valid  = 1'b1;
    req_store  = st;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    #1;
    if (m_illegal(st, f3, addr)) begin
      check_val("fault_pulse", fault, 1'b1);
      check_val("fault_stall", stall, 1'b0);
      tick();
      req_valid = 1'b0;
      check_held("fault_after");
      return;
    end
    check_val("accept_fault", fault, 1'b0);
    check_val("accept_stall", stall, 1'b1);
    tick();
    exp_addr  = addr & 32'hFFFF_FFFC;
    exp_mbe   = m_mbe(f3, addr);
    exp_wdata = m_wdata(st, f3, wd);
    req_valid  = 1'b0;
    req_store  = $urandom;
    req_funct3 = $urandom;
    req_addr   = $urandom;
    req_wdata  = $urandom;
    check_val("busy_addr", data_mem_address, exp_addr);
    check_val("busy_read", data_mem_read, !st);
    check_val("busy_write", data_mem_write, st);
    check_val("busy_mbe", data_mem_byte_enable, exp_mbe);
    check_val("busy_wdata", data_mem_wdata, exp_wdata);
    stall_low = 0;
    for (int i = 1; i < delay; i++) begin
      if (stall !== 1'b1 || done !== 1'b0) stall_low++;
      tick();
    end
    data_mem_resp  = 1'b1;
    data_mem_rdata = rd;
    #1;
    check_val("busy_stall_lost", stall_low, 0);
    check_val("resp_stall", stall, 1'b1);
    check_val("resp_strobe", {data_mem_read, data_mem_write}, {!st, st});
    check_val("resp_wdata_held", data_mem_wdata, exp_wdata);
    tick();
    data_mem_resp = 1'b0;
    if (!st) exp_mdr = rd;
    exp_last = (delay > LAT_CAP) ? LAT_W'(LAT_CAP) : LAT_W'(delay);
    check_val("done_pulse", done, 1'b1);
    check_val("done_stall", stall, 1'b0);
    check_val("done_read", data_mem_read, 1'b0);
    check_val("done_write", data_mem_write, 1'b0);
    check_val("done_mdr", mdrreg_out, exp_mdr);
    check_val("done_latency", last_latency, exp_last);
    check_val("done_mbe", data_mem_byte_enable, exp_mbe);
    if (hold_next) begin
      data_mem_resp  = 1'b1;
      data_mem_rdata = ~rd;
      req_valid      = 1'b1;
      req_store      = 1'b1;
      req_funct3     = 3'b010;
      req_addr       = 32'h0000_0040;
      #1;
      check_val("done_stall_vld", stall, 1'b0);
    end
    tick();
    data_mem_resp = 1'b0;
    check_held("post_done");
    check_val("post_done_latency", last_latency, exp_last);
    req_valid = 1'b0;
  endtask

  initial begin
    rst            = 1'b0;
    req_valid      = 1'b0;
    req_store      = 1'b0;
    req_funct3     = 3'b000;
    req_addr       = 32'h0;
    req_wdata      = 32'h0;
    data_mem_resp  = 1'b0;
    data_mem_rdata = 32'h0;
    tick();
    tick();
    check_val("rst_addr", data_mem_address, 32'h0);
    check_val("rst_wdata", data_mem_wdata, 32'h0);
    check_val("rst_stall", stall, 1'b0);
    check_val("rst_fault", fault, 1'b0);
    check_val("rst_latency", last_latency, 32'h0);
    check_held("rst");
    rst = 1'b1;
    tick();

    // sb to byte 3, resp in second BUSY cycle.
    do_access(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 2, 32'h0, 1'b0);
    check_val("sb_mbe", data_mem_byte_enable, 4'b1000);
    check_val("sb_wdata", data_mem_wdata, 32'hDDDD_DDDD);
    check_val("sb_latency", last_latency, 32'd2);

    // lh from upper half, resp immediately.
    do_access(1'b0, 3'b001, 32'h0000_2002, 32'h0, 1, 32'h8001_7FFF, 1'b0);
    check_val("lh_mdr", mdrreg_out, 32'h8001_7FFF);
    check_val("lh_mbe", data_mem_byte_enable, 4'b1100);

    // Misaligned lw and lhu both fault.
    do_access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 1, 32'h0, 1'b0);
    do_access(1'b0, 3'b101, 32'h0000_3001, 32'h0, 1, 32'h0, 1'b0);
    // Stores with unsigned funct3 fault.
    do_access(1'b1, 3'b100, 32'h0000_3000, 32'h0, 1, 32'h0, 1'b0);

    // Spurious resps in IDLE and DONE, then back-to-back sw.
    spur_idle();
    do_access(1'b0, 3'b100, 32'h0000_5001, 32'h0, 3, 32'h1234_5678, 1'b1);
    do_access(1'b1, 3'b010, 32'h0000_6004, 32'hCAFE_F00D, 1, 32'h0, 1'b0);
    check_val("sw_mbe", data_mem_byte_enable, 4'b1111);
    check_val("sw_wdata", data_mem_wdata, 32'hCAFE_F00D);
    check_val("sw_mdr_kept", mdrreg_out, 32'h1234_5678);

    // Reset in the middle of a load.
    req_valid  = 1'b1;
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_7000;
    tick();
    req_valid = 1'b0;
    check_val("mid_read_pre", data_mem_read, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_mbe = 4'h0; exp_mdr = 32'h0; exp_last = '0;
    check_val("mid_rst_stall", stall, 1'b0);
    check_held("mid_rst");
    data_mem_resp  = 1'b1;
    data_mem_rdata = 32'hDEAD_BEEF;
    tick();
    data_mem_resp = 1'b0;
    check_held("mid_rst_resp");
    tick();
    check_held("mid_rst_later");
    check_val("mid_rst_latency", last_latency, 32'h0);

    // Randomized ops.
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) spur_idle();
        else tick();
      end
      do_access($urandom_range(0, 1), 3'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(1, 6), $urandom, 1'($urandom_range(0, 1)));
    end

    // Latency saturation with a long-withheld resp.
    do_access(1'b0, 3'b010, 32'h0000_8000, 32'h0, 70000, 32'h0BAD_F00D, 1'b0);
    check_val("sat_latency", last_latency, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
